add_serial_sched: RTL and testbench

ADD_SERIAL_SCHED -- requirements
Module: add_serial_sched

---
 rtl/add_serial_sched_pkg.sv | 21 ++
 rtl/add_serial_sched_rr.sv | 47 ++++
 rtl/add_serial_sched.sv | 161 ++++++++++++++++
 tb/tb_add_serial_sched.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_serial_sched_pkg.sv
// Shared types and defaults for the serial-adder scheduler.
// Holds the FSM state enum, default parameters and an index-width helper.
package add_serial_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    localparam int N_REQ_DEF   = 4;
    localparam int W_DEF       = 8;
    localparam int ADD_LAT_DEF = 10;
    localparam int CNT_W       = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_serial_sched_rr.sv
// Combinational round-robin winner select for the serial-adder scheduler.
// Ports: req (requests), ptr (search start) -> onehot, idx, valid.
module rr_arb
    import add_serial_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    logic [IW-1:0] lo_any;
    logic [IW-1:0] lo_hi;
    logic          any_hi;

    // Lowest request at or above ptr wins; otherwise wrap to the
    // lowest request overall.
    always_comb begin
        lo_any = '0;
        lo_hi  = '0;
        any_hi = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_any = IW'(i);
            end
            if (req[i] && (i >= int'(ptr))) begin
                lo_hi  = IW'(i);
                any_hi = 1'b1;
            end
        end
    end

    assign valid = |req;
    assign idx   = any_hi ? lo_hi : lo_any;

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            onehot[i] = valid && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one multi-cycle serial adder among N_REQ
// requesters. Ports: clk, rst (async, active-high), req/op_a/op_b in,
// gnt out, add_en/add_a/add_b/add_out adder side, res_valid/res_id/
// res_data/res_ready result handshake, busy. Optional ops_done counter
// under macro ADD_SERIAL_SCHED_STATS_EN.
module add_serial_sched
    import add_serial_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int W       = W_DEF,
    parameter int ADD_LAT = ADD_LAT_DEF,
    parameter int IW      = idx_w(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] op_a,
    input  logic [N_REQ*W-1:0] op_b,
    output logic [N_REQ-1:0]   gnt,
    output logic               add_en,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    input  logic [W-1:0]       add_out,
    output logic               res_valid,
    output logic [IW-1:0]      res_id,
    output logic [W-1:0]       res_data,
    input  logic               res_ready,
    output logic               busy
`ifdef ADD_SERIAL_SCHED_STATS_EN
    ,
    output logic [15:0]        ops_done
`endif
);

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] arb_onehot;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic             take;
    logic             done;
    logic             hs;

    rr_arb #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (arb_onehot),
        .idx    (arb_idx),
        .valid  (arb_valid)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_onehot[i]) begin
                sel_a = op_a[i*W +: W];
                sel_b = op_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        gnt       = '0;
        add_en    = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        take      = 1'b0;
        done      = 1'b0;
        hs        = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (arb_valid) begin
                    gnt      = arb_onehot;
                    take     = 1'b1;
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: begin
                add_en   = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    done     = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    hs       = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operands and index are captured at grant so later req/operand
    // changes cannot disturb the operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            cnt      <= '0;
            add_a    <= '0;
            add_b    <= '0;
            res_id   <= '0;
            res_data <= '0;
        end else begin
            if (take) begin
                add_a  <= sel_a;
                add_b  <= sel_b;
                res_id <= arb_idx;
            end
            if (add_en) begin
                cnt <= CNT_W'(ADD_LAT - 1);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (done) begin
                res_data <= add_out;
            end
            if (hs) begin
                rr_ptr <= (res_id == IW'(N_REQ - 1)) ? '0 : res_id + 1'b1;
            end
        end
    end

`ifdef ADD_SERIAL_SCHED_STATS_EN
    logic [15:0] ops_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_cnt <= '0;
        end else if (hs) begin
            ops_cnt <= ops_cnt + 16'd1;
        end
    end

    assign ops_done = ops_cnt;
`endif

endmodule

// File: tb/tb_add_serial_sched.sv
// Self-checking bench for add_serial_sched: time-based transaction model,
// per-cycle compare on the falling edge, plus directed literal checks.
module tb_add_serial_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 10;
    localparam int IW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic [N-1:0]   gnt;
    logic           add_en;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_out;
    logic           res_valid;
    logic [IW-1:0]  res_id;
    logic [W-1:0]   res_data;
    logic           res_ready;
    logic           busy;
`ifdef ADD_SERIAL_SCHED_STATS_EN
    logic [15:0]    ops_done;
`endif

    add_serial_sched #(
        .N_REQ   (N),
        .W       (W),
        .ADD_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy)
`ifdef ADD_SERIAL_SCHED_STATS_EN
        ,
        .ops_done  (ops_done)
`endif
    );

    always #5 clk = ~clk;

    // Serial adder model: result visible only in cycle add_en + LAT.
    int           lat_cnt;
    logic [W-1:0] lat_sum;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= 0;
            lat_sum <= '0;
        end else if (add_en) begin
            lat_cnt <= 1;
            lat_sum <= add_a + add_b;
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt + 1;
        end
    end

    assign add_out = (lat_cnt == LAT) ? lat_sum : 8'hEE;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Model state
    int           cyc = 0;
    bit           act = 0;
    int           gc = 0;
    int           gid = 0;
    logic [W-1:0] ga, gb, gsum;
    int           mptr = 0;
    logic [15:0]  mops = 0;

    // Observation log
    int           gq_cyc[$];
    int           gq_id[$];
    int           en_cyc = -1;
    int           rv_cyc = -1;
    int           hs_cyc = -1;
    int           hs_id = -1;
    int           hs_n = 0;
    logic [W-1:0] hs_data = '0;
    logic         rv_prev = 1'b0;

    always @(negedge clk) begin
        bit           found;
        int           w;
        logic [N-1:0] exp_gnt;
        bit           exp_rv;
        if (rst) begin
            act  = 0;
            mptr = 0;
            mops = 0;
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_add_en", 32'(add_en), 0);
            chk("rst_res_valid", 32'(res_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_add_a", 32'(add_a), 0);
            chk("rst_add_b", 32'(add_b), 0);
            chk("rst_res_id", 32'(res_id), 0);
            chk("rst_res_data", 32'(res_data), 0);
`ifdef ADD_SERIAL_SCHED_STATS_EN
            chk("rst_ops_done", 32'(ops_done), 0);
`endif
        end else begin
            found   = 0;
            w       = 0;
            exp_gnt = '0;
            exp_rv  = act && (cyc >= gc + LAT + 2);
            if (!act) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (mptr + k) % N;
                    if (!found && req[j]) begin
                        found = 1;
                        w     = j;
                    end
                end
                if (found) exp_gnt[w] = 1'b1;
            end
            chk("gnt", 32'(gnt), 32'(exp_gnt));
            chk("add_en", 32'(add_en), 32'(act && (cyc == gc + 1)));
            chk("res_valid", 32'(res_valid), 32'(exp_rv));
            chk("busy", 32'(busy), 32'(act));
            if (act && cyc >= gc + 1 && cyc <= gc + LAT) begin
                chk("add_a", 32'(add_a), 32'(ga));
                chk("add_b", 32'(add_b), 32'(gb));
            end
            if (exp_rv) begin
                chk("res_id", 32'(res_id), gid);
                chk("res_data", 32'(res_data), 32'(gsum));
            end
`ifdef ADD_SERIAL_SCHED_STATS_EN
            chk("ops_done", 32'(ops_done), 32'(mops));
`endif
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    gq_cyc.push_back(cyc);
                    gq_id.push_back(i);
                end
            end
            if (add_en) en_cyc = cyc;
            if (res_valid && !rv_prev) rv_cyc = cyc;
            if (res_valid && res_ready) begin
                hs_cyc  = cyc;
                hs_id   = int'(res_id);
                hs_data = res_data;
                hs_n++;
            end
            if (!act && found) begin
                act  = 1;
                gc   = cyc;
                gid  = w;
                ga   = op_a[w*W +: W];
                gb   = op_b[w*W +: W];
                gsum = ga + gb;
            end else if (exp_rv && res_ready) begin
                act  = 0;
                mptr = (gid + 1) % N;
                mops = mops + 16'd1;
            end
        end
        rv_prev = res_valid;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single request, ptr 0 -> requester 0, 0x35+0x4A
        gq_cyc.delete();
        gq_id.delete();
        op_a[0*W +: W] = 8'h35;
        op_b[0*W +: W] = 8'h4A;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        op_a[0*W +: W] = 8'h00;
        repeat (13) tick();
        chk("t1_ngrants", gq_cyc.size(), 1);
        chk("t1_gid", gq_id[0], 0);
        chk("t1_en_lat", en_cyc - gq_cyc[0], 1);
        chk("t1_rv_lat", rv_cyc - gq_cyc[0], 12);
        chk("t1_data", 32'(hs_data), 32'h7F);
        chk("t1_id", hs_id, 0);

        // Overflow on requester 2 (ptr now 1)
        op_a[2*W +: W] = 8'hFF;
        op_b[2*W +: W] = 8'h02;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        repeat (13) tick();
        chk("t2_data", 32'(hs_data), 32'h01);
        chk("t2_id", hs_id, 2);

        // Fairness from a fresh reset
        do_reset();
        tick();
        gq_cyc.delete();
        gq_id.delete();
        for (int i = 0; i < N; i++) begin
            op_a[i*W +: W] = 8'(8'h11 * i + 1);
            op_b[i*W +: W] = 8'(8'h10 * i + 3);
        end
        req = 4'b1111;
        repeat (104) tick();
        req = 4'b0000;
        repeat (3) tick();
        chk("t3_ngrants", gq_cyc.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < gq_id.size()) chk("t3_order", gq_id[i], i % 4);
        end
        if (gq_cyc.size() >= 8) chk("t3_period", gq_cyc[7] - gq_cyc[6], 13);

        // Backpressure: 5 cycles of res_ready low in RESP
        gq_cyc.delete();
        gq_id.delete();
        res_ready = 1'b0;
        req = 4'b1111;
        repeat (17) tick();
        res_ready = 1'b1;
        tick();
        tick();
        req = 4'b0000;
        chk("t4_ngrants", gq_cyc.size(), 2);
        if (gq_cyc.size() >= 2) begin
            chk("t4_gap_hs", gq_cyc[1] - hs_cyc, 1);
            chk("t4_gap", gq_cyc[1] - gq_cyc[0], 18);
            chk("t4_id0", gq_id[0], 0);
            chk("t4_id1", gq_id[1], 1);
        end
        repeat (13) tick();

        // Reset during WAIT (ptr now 2)
        gq_cyc.delete();
        gq_id.delete();
        req = 4'b1100;
        tick();
        req = 4'b0000;
        repeat (4) tick();
        begin
            int hs_before;
            hs_before = hs_n;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tick();
            req = 4'b1010;
            tick();
            req = 4'b0000;
            chk("t5_first_id", gq_id.size() > 0 ? gq_id[0] : -1, 2);
            chk("t5_ngrants", gq_cyc.size(), 2);
            chk("t5_next_id", gq_id.size() > 1 ? gq_id[1] : -1, 1);
            chk("t5_no_result", hs_n, hs_before);
            repeat (13) tick();
        end

`ifdef ADD_SERIAL_SCHED_STATS_EN
        do_reset();
        tick();
        for (int n = 0; n < 3; n++) begin
            req = 4'b0001;
            tick();
            req = 4'b0000;
            repeat (13) tick();
        end
        chk("t6_ops3", 32'(ops_done), 3);
        dut.ops_cnt = 16'hFFFF;
        mops = 16'hFFFF;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        repeat (13) tick();
        chk("t6_wrap", 32'(ops_done), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
